axis_stream_checker: RTL and testbench

//  Synthesizable AXIS sink: the receiving end of the AXIS stimulus path. It accepts packets from a DUT master,

---
 rtl/axis_chk_pkg.sv | 30 +++
 rtl/axis_stream_checker_lfsr.sv | 37 +++
 rtl/axis_stream_checker.sv | 175 +++++++++++++++++
 tb/tb_axis_stream_checker.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_chk_pkg.sv
// Shared types and helpers for the AXIS stream checker: FSM states, LFSR polynomial,
// and width helpers used by the top and the backpressure LFSR.
package axis_chk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } chk_state_e;

  // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Galois form
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic int clog2_min1(input int n);
    if (n <= 32'sd1) begin
      return 32'sd1;
    end else begin
      return $clog2(n);
    end
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    if (v[0]) begin
      return {1'b0, v[15:1]} ^ LFSR_TAPS;
    end else begin
      return {1'b0, v[15:1]};
    end
  endfunction

endpackage

// File: rtl/axis_stream_checker_lfsr.sv
// 16-bit Galois LFSR that paces tready when backpressure is enabled.
// Advances only when step is high; loads seed on reset.
module lfsr_ready_gen
  import axis_chk_pkg::*;
(
  input  logic        aclk,
  input  logic        arst,
  input  logic        step,
  input  logic [15:0] seed,
  output logic [15:0] lfsr_out
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // Next LFSR value: advance on step, otherwise hold
  always_comb begin
    lfsr_d = lfsr_q;
    if (step) begin
      lfsr_d = lfsr_step(lfsr_q);
    end else begin
      lfsr_d = lfsr_q;
    end
  end

  // LFSR state register
  always_ff @(posedge aclk) begin
    if (arst) begin
      lfsr_q <= seed;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr_out = lfsr_q;

endmodule

// File: rtl/axis_stream_checker.sv
// AXIS sink that checks each accepted beat against a per-packet byte ramp and
// reports sticky error flags plus packet / error-beat counters.
module axis_stream_checker
  import axis_chk_pkg::*;
#(
  parameter int          BUS_WIDTH     = 1,
  parameter int          USER_WIDTH    = 1,
  parameter int          DEST_WIDTH    = 1,
  parameter int          PKT_BEATS     = 16,
  parameter int          BACKPRESSURE  = 0,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1,
  parameter int          STOP_ON_ERROR = 0
) (
  input  logic                   aclk,
  input  logic                   arst,
  input  logic                   enable,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic [BUS_WIDTH*8-1:0] s_axis_tdata,
  input  logic [BUS_WIDTH-1:0]   s_axis_tkeep,
  input  logic                   s_axis_tlast,
  input  logic [USER_WIDTH-1:0]  s_axis_tuser,
  input  logic [DEST_WIDTH-1:0]  s_axis_tdest,
  output logic                   err_data,
  output logic                   err_keep,
  output logic                   err_last,
  output logic [31:0]            pkt_count,
  output logic [15:0]            error_count,
  output logic                   halted
);

  localparam int              BIW      = clog2_min1(PKT_BEATS);
  localparam logic [BIW-1:0]  LAST_IDX = BIW'(PKT_BEATS - 1);

  chk_state_e       state_q, state_d;
  logic             tready_q, tready_d;
  logic             halted_q, halted_d;
  logic [BIW-1:0]   beat_idx_q, beat_idx_d;
  logic [7:0]       byte_base_q, byte_base_d;
  logic             err_data_q, err_data_d;
  logic             err_keep_q, err_keep_d;
  logic             err_last_q, err_last_d;
  logic [31:0]      pkt_count_q, pkt_count_d;
  logic [15:0]      error_count_q, error_count_d;

  logic             accept_s;
  logic [BUS_WIDTH-1:0] lane_err_s;
  logic             data_err_s;
  logic             keep_err_s;
  logic             last_exp_s;
  logic             last_err_s;
  logic             beat_err_s;
  logic             lfsr_step_s;
  logic [15:0]      lfsr_s;
  logic [15:0]      lfsr_next_s;
  logic             unused_s;

  assign accept_s = s_axis_tvalid & tready_q;

  for (genvar g = 0; g < BUS_WIDTH; g++) begin : g_lane
    assign lane_err_s[g] = (s_axis_tdata[g*8 +: 8] != (byte_base_q + 8'(g)));
  end

  assign data_err_s = |lane_err_s;
  assign keep_err_s = (s_axis_tkeep != {BUS_WIDTH{1'b1}});
  assign last_exp_s = (beat_idx_q == LAST_IDX);
  assign last_err_s = s_axis_tlast ^ last_exp_s;
  assign beat_err_s = accept_s & (data_err_s | keep_err_s | last_err_s);

  // The LFSR advances on every RUN cycle; tready is computed from the value it will hold next
  assign lfsr_step_s = (state_q == RUN);
  assign lfsr_next_s = lfsr_step_s ? lfsr_step(lfsr_s) : lfsr_s;

  lfsr_ready_gen u_lfsr (
    .aclk     (aclk),
    .arst     (arst),
    .step     (lfsr_step_s),
    .seed     (LFSR_SEED),
    .lfsr_out (lfsr_s)
  );

  // Run-state FSM plus the registered tready / halted decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (enable) state_d = RUN;
        else        state_d = IDLE;
      end
      RUN: begin
        if (beat_err_s && (STOP_ON_ERROR != 0)) state_d = HALT;
        else if (!enable)                        state_d = IDLE;
        else                                     state_d = RUN;
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
    tready_d = (state_d == RUN) & ((BACKPRESSURE != 0) ? lfsr_next_s[0] : 1'b1);
    halted_d = (state_d == HALT);
  end

  // Pattern position, sticky flags and counters, updated on each accepted beat
  always_comb begin
    beat_idx_d    = beat_idx_q;
    byte_base_d   = byte_base_q;
    err_data_d    = err_data_q;
    err_keep_d    = err_keep_q;
    err_last_d    = err_last_q;
    pkt_count_d   = pkt_count_q;
    error_count_d = error_count_q;
    if (accept_s) begin
      // A missing tlast on the final beat still forces a packet boundary, but is not counted as a packet
      if (s_axis_tlast) begin
        beat_idx_d  = '0;
        byte_base_d = 8'd0;
        pkt_count_d = pkt_count_q + 32'd1;
      end else if (last_exp_s) begin
        beat_idx_d  = '0;
        byte_base_d = 8'd0;
      end else begin
        beat_idx_d  = beat_idx_q + BIW'(1'b1);
        byte_base_d = byte_base_q + 8'(BUS_WIDTH);
      end
      err_data_d = err_data_q | data_err_s;
      err_keep_d = err_keep_q | keep_err_s;
      err_last_d = err_last_q | last_err_s;
      if (beat_err_s && (error_count_q != 16'hFFFF)) begin
        error_count_d = error_count_q + 16'd1;
      end else begin
        error_count_d = error_count_q;
      end
    end else begin
      beat_idx_d = beat_idx_q;
    end
  end

  // State and output registers
  always_ff @(posedge aclk) begin
    if (arst) begin
      state_q       <= IDLE;
      tready_q      <= 1'b0;
      halted_q      <= 1'b0;
      beat_idx_q    <= '0;
      byte_base_q   <= 8'd0;
      err_data_q    <= 1'b0;
      err_keep_q    <= 1'b0;
      err_last_q    <= 1'b0;
      pkt_count_q   <= 32'd0;
      error_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      tready_q      <= tready_d;
      halted_q      <= halted_d;
      beat_idx_q    <= beat_idx_d;
      byte_base_q   <= byte_base_d;
      err_data_q    <= err_data_d;
      err_keep_q    <= err_keep_d;
      err_last_q    <= err_last_d;
      pkt_count_q   <= pkt_count_d;
      error_count_q <= error_count_d;
    end
  end

  assign s_axis_tready = tready_q;
  assign halted        = halted_q;
  assign err_data      = err_data_q;
  assign err_keep      = err_keep_q;
  assign err_last      = err_last_q;
  assign pkt_count     = pkt_count_q;
  assign error_count   = error_count_q;

  // Sideband fields are carried but deliberately not checked
  assign unused_s = ^{s_axis_tuser, s_axis_tdest, lfsr_next_s[15:1]};

endmodule

// File: tb/tb_axis_stream_checker.sv
// Directed bench for axis_stream_checker: three instances (plain, backpressure,
// stop-on-error) sharing one stimulus bus; each test observes its own instance.
module tb_axis_stream_checker;

  logic        aclk = 1'b0;
  logic        arst;
  logic        enable;
  logic        tvalid;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tlast;
  logic [0:0]  tuser;
  logic [0:0]  tdest;

  logic        rdy    [3];
  logic        e_data [3];
  logic        e_keep [3];
  logic        e_last [3];
  logic [31:0] pc     [3];
  logic [15:0] ec     [3];
  logic        hlt    [3];

  int checks   = 0;
  int failures = 0;

  always #5 aclk = ~aclk;

  axis_stream_checker #(.BUS_WIDTH(4), .PKT_BEATS(4), .BACKPRESSURE(0), .STOP_ON_ERROR(0)) dut_a (
    .aclk(aclk), .arst(arst), .enable(enable), .s_axis_tvalid(tvalid), .s_axis_tready(rdy[0]),
    .s_axis_tdata(tdata), .s_axis_tkeep(tkeep), .s_axis_tlast(tlast), .s_axis_tuser(tuser),
    .s_axis_tdest(tdest), .err_data(e_data[0]), .err_keep(e_keep[0]), .err_last(e_last[0]),
    .pkt_count(pc[0]), .error_count(ec[0]), .halted(hlt[0]));

  axis_stream_checker #(.BUS_WIDTH(4), .PKT_BEATS(4), .BACKPRESSURE(1), .LFSR_SEED(16'hACE1),
                        .STOP_ON_ERROR(0)) dut_b (
    .aclk(aclk), .arst(arst), .enable(enable), .s_axis_tvalid(tvalid), .s_axis_tready(rdy[1]),
    .s_axis_tdata(tdata), .s_axis_tkeep(tkeep), .s_axis_tlast(tlast), .s_axis_tuser(tuser),
    .s_axis_tdest(tdest), .err_data(e_data[1]), .err_keep(e_keep[1]), .err_last(e_last[1]),
    .pkt_count(pc[1]), .error_count(ec[1]), .halted(hlt[1]));

  axis_stream_checker #(.BUS_WIDTH(4), .PKT_BEATS(4), .BACKPRESSURE(0), .STOP_ON_ERROR(1)) dut_c (
    .aclk(aclk), .arst(arst), .enable(enable), .s_axis_tvalid(tvalid), .s_axis_tready(rdy[2]),
    .s_axis_tdata(tdata), .s_axis_tkeep(tkeep), .s_axis_tlast(tlast), .s_axis_tuser(tuser),
    .s_axis_tdest(tdest), .err_data(e_data[2]), .err_keep(e_keep[2]), .err_last(e_last[2]),
    .pkt_count(pc[2]), .error_count(ec[2]), .halted(hlt[2]));

  typedef struct {
    bit          rst;
    logic [31:0] data;
    logic [3:0]  keep;
    bit          last;
    logic [2:0]  flags;   // {err_data, err_keep, err_last} after the accept
    logic [15:0] ec;
    logic [31:0] pc;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(bit r, logic [31:0] d, logic [3:0] k, bit l,
                              logic [2:0] f, logic [15:0] e, logic [31:0] p);
    vec_t v;
    v.rst = r; v.data = d; v.keep = k; v.last = l; v.flags = f; v.ec = e; v.pc = p;
    vecs.push_back(v);
  endfunction

  function automatic logic [31:0] ramp(input int j);
    return {8'(4*j+3), 8'(4*j+2), 8'(4*j+1), 8'(4*j)};
  endfunction

  function automatic logic [15:0] gal(input logic [15:0] v);
    logic [15:0] t;
    t = {1'b0, v[15:1]};
    if (v[0]) t = t ^ 16'hB400;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    arst = 1'b1; enable = 1'b0; tvalid = 1'b0; tlast = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    arst = 1'b0;
  endtask

  task automatic check_zero(input int s, input string tag);
    chk({tag, "_tready"}, {31'd0, rdy[s]}, 32'd0);
    chk({tag, "_flags"}, {29'd0, e_data[s], e_keep[s], e_last[s]}, 32'd0);
    chk({tag, "_pkt"}, pc[s], 32'd0);
    chk({tag, "_errcnt"}, {16'd0, ec[s]}, 32'd0);
    chk({tag, "_halted"}, {31'd0, hlt[s]}, 32'd0);
  endtask

  // Present one beat and hold it until instance s accepts it, or the budget expires
  task automatic send_beat(input int s, input logic [31:0] d, input logic [3:0] k,
                           input bit l, output bit ok);
    tvalid = 1'b1; tdata = d; tkeep = k; tlast = l; ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (rdy[s]) ok = 1'b1;
      @(posedge aclk);
      #1;
      if (ok) break;
    end
    tvalid = 1'b0; tlast = 1'b0;
  endtask

  task automatic send_pkt_beats(input int s, input int first, input int last_beat);
    bit ok;
    for (int j = first; j <= last_beat; j++) begin
      send_beat(s, ramp(j), 4'hF, (j == 3), ok);
      chk($sformatf("accept_inst%0d_beat%0d", s, j), {31'd0, ok}, 32'd1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    bit          ok;
    logic [15:0] m_lfsr;
    logic        m_rdy;
    int          beats;
    int          cyc;

    tdata = 32'd0; tkeep = 4'hF; tuser = 1'b0; tdest = 1'b0;

    // clean packets
    add(1, 32'h03020100, 4'hF, 0, 3'b000, 16'd0, 32'd0);
    add(0, 32'h07060504, 4'hF, 0, 3'b000, 16'd0, 32'd0);
    add(0, 32'h0B0A0908, 4'hF, 0, 3'b000, 16'd0, 32'd0);
    add(0, 32'h0F0E0D0C, 4'hF, 1, 3'b000, 16'd0, 32'd1);
    add(0, 32'h03020100, 4'hF, 0, 3'b000, 16'd0, 32'd1);
    add(0, 32'h07060504, 4'hF, 0, 3'b000, 16'd0, 32'd1);
    add(0, 32'h0B0A0908, 4'hF, 0, 3'b000, 16'd0, 32'd1);
    add(0, 32'h0F0E0D0C, 4'hF, 1, 3'b000, 16'd0, 32'd2);
    add(0, 32'h03020100, 4'hF, 0, 3'b000, 16'd0, 32'd2);
    add(0, 32'h07060504, 4'hF, 0, 3'b000, 16'd0, 32'd2);
    add(0, 32'h0B0A0908, 4'hF, 0, 3'b000, 16'd0, 32'd2);
    add(0, 32'h0F0E0D0C, 4'hF, 1, 3'b000, 16'd0, 32'd3);
    // corrupted byte 0x05 in the second packet
    add(1, 32'h03020100, 4'hF, 0, 3'b000, 16'd0, 32'd0);
    add(0, 32'h07060504, 4'hF, 0, 3'b000, 16'd0, 32'd0);
    add(0, 32'h0B0A0908, 4'hF, 0, 3'b000, 16'd0, 32'd0);
    add(0, 32'h0F0E0D0C, 4'hF, 1, 3'b000, 16'd0, 32'd1);
    add(0, 32'h03020100, 4'hF, 0, 3'b000, 16'd0, 32'd1);
    add(0, 32'h0706FF04, 4'hF, 0, 3'b100, 16'd1, 32'd1);
    add(0, 32'h0B0A0908, 4'hF, 0, 3'b100, 16'd1, 32'd1);
    add(0, 32'h0F0E0D0C, 4'hF, 1, 3'b100, 16'd1, 32'd2);
    // early tlast, clean packet, missing tlast, clean packet
    add(1, 32'h03020100, 4'hF, 0, 3'b000, 16'd0, 32'd0);
    add(0, 32'h07060504, 4'hF, 1, 3'b001, 16'd1, 32'd1);
    add(0, 32'h03020100, 4'hF, 0, 3'b001, 16'd1, 32'd1);
    add(0, 32'h07060504, 4'hF, 0, 3'b001, 16'd1, 32'd1);
    add(0, 32'h0B0A0908, 4'hF, 0, 3'b001, 16'd1, 32'd1);
    add(0, 32'h0F0E0D0C, 4'hF, 1, 3'b001, 16'd1, 32'd2);
    add(0, 32'h03020100, 4'hF, 0, 3'b001, 16'd1, 32'd2);
    add(0, 32'h07060504, 4'hF, 0, 3'b001, 16'd1, 32'd2);
    add(0, 32'h0B0A0908, 4'hF, 0, 3'b001, 16'd1, 32'd2);
    add(0, 32'h0F0E0D0C, 4'hF, 0, 3'b001, 16'd2, 32'd2);
    add(0, 32'h03020100, 4'hF, 0, 3'b001, 16'd2, 32'd2);
    add(0, 32'h07060504, 4'hF, 0, 3'b001, 16'd2, 32'd2);
    add(0, 32'h0B0A0908, 4'hF, 0, 3'b001, 16'd2, 32'd2);
    add(0, 32'h0F0E0D0C, 4'hF, 1, 3'b001, 16'd2, 32'd3);
    // three errors in one beat count once; pattern restarts after it
    add(1, 32'h030201AA, 4'h7, 1, 3'b111, 16'd1, 32'd1);
    add(0, 32'h03020100, 4'hF, 0, 3'b111, 16'd1, 32'd1);
    add(0, 32'h07060504, 4'hF, 0, 3'b111, 16'd1, 32'd1);

    // reset state of every instance
    do_reset();
    check_zero(0, "rst_a");
    check_zero(1, "rst_b");
    check_zero(2, "rst_c");

    // table-driven beats on the plain instance
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) begin
        do_reset();
        enable = 1'b1;
      end
      send_beat(0, vecs[i].data, vecs[i].keep, vecs[i].last, ok);
      chk($sformatf("vec%0d_accept", i), {31'd0, ok}, 32'd1);
      chk($sformatf("vec%0d_flags", i), {29'd0, e_data[0], e_keep[0], e_last[0]},
          {29'd0, vecs[i].flags});
      chk($sformatf("vec%0d_errcnt", i), {16'd0, ec[0]}, {16'd0, vecs[i].ec});
      chk($sformatf("vec%0d_pkt", i), pc[0], vecs[i].pc);
    end

    // tready stays high through idle RUN cycles
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge aclk);
      #1;
      chk($sformatf("run_tready_%0d", i), {31'd0, rdy[0]}, 32'd1);
    end

    // enable drop mid-packet: tready falls, position held, packet resumes cleanly
    send_pkt_beats(0, 0, 1);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge aclk);
      #1;
      chk($sformatf("paused_tready_%0d", i), {31'd0, rdy[0]}, 32'd0);
    end
    enable = 1'b1;
    send_pkt_beats(0, 2, 3);
    chk("resume_flags", {29'd0, e_data[0], e_keep[0], e_last[0]}, 32'd0);
    chk("resume_errcnt", {16'd0, ec[0]}, 32'd0);
    chk("resume_pkt", pc[0], 32'd1);

    // reset pulsed mid-packet, then a clean packet from scratch
    send_pkt_beats(0, 0, 2);
    arst = 1'b1;
    @(posedge aclk);
    #1;
    arst = 1'b0;
    check_zero(0, "midrst");
    send_pkt_beats(0, 0, 3);
    chk("postrst_pkt", pc[0], 32'd1);
    chk("postrst_errcnt", {16'd0, ec[0]}, 32'd0);
    chk("postrst_flags", {29'd0, e_data[0], e_keep[0], e_last[0]}, 32'd0);

    // stop-on-error: bad tkeep on beat 2 halts and freezes the instance
    do_reset();
    enable = 1'b1;
    send_pkt_beats(2, 0, 1);
    send_beat(2, ramp(2), 4'b0111, 1'b0, ok);
    chk("halt_accept", {31'd0, ok}, 32'd1);
    chk("halt_flags", {29'd0, e_data[2], e_keep[2], e_last[2]}, 32'd2);
    chk("halt_halted", {31'd0, hlt[2]}, 32'd1);
    chk("halt_tready", {31'd0, rdy[2]}, 32'd0);
    chk("halt_errcnt", {16'd0, ec[2]}, 32'd1);
    tvalid = 1'b1; tdata = 32'hDEADBEEF; tkeep = 4'h0; tlast = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge aclk);
      #1;
      chk($sformatf("halt_hold_tready_%0d", i), {31'd0, rdy[2]}, 32'd0);
    end
    tvalid = 1'b0; tlast = 1'b0;
    chk("halt_hold_errcnt", {16'd0, ec[2]}, 32'd1);
    chk("halt_hold_pkt", pc[2], 32'd0);
    chk("halt_hold_halted", {31'd0, hlt[2]}, 32'd1);
    do_reset();
    check_zero(2, "unhalt");

    // backpressure: tready follows the golden LFSR, tvalid held for 64 beats
    do_reset();
    m_lfsr = 16'hACE1;
    m_rdy  = 1'b0;
    beats  = 0;
    cyc    = 0;
    enable = 1'b1;
    tvalid = 1'b1; tdata = ramp(0); tkeep = 4'hF; tlast = 1'b0;
    while (beats < 64 && cyc < 2000) begin
      ok = rdy[1];
      @(posedge aclk);
      #1;
      if (cyc == 0) m_rdy = m_lfsr[0];
      else begin
        m_lfsr = gal(m_lfsr);
        m_rdy  = m_lfsr[0];
      end
      chk($sformatf("bp_tready_cyc%0d", cyc), {31'd0, rdy[1]}, {31'd0, m_rdy});
      cyc++;
      if (ok) begin
        beats++;
        tdata = ramp(beats % 4);
        tlast = ((beats % 4) == 3);
      end
    end
    tvalid = 1'b0; tlast = 1'b0;
    chk("bp_beats", beats, 64);
    chk("bp_pkt", pc[1], 32'd16);
    chk("bp_errcnt", {16'd0, ec[1]}, 32'd0);
    chk("bp_flags", {29'd0, e_data[1], e_keep[1], e_last[1]}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
